// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write engine: FSM states, quarter-phase
// encoding, counter widths and the codec write address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Quarter of a bit slot: Q0/Q1 have SCL low, Q2/Q3 have SCL high.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_e;

  localparam int BIT_CNT_W  = 3;
  localparam int BYTE_CNT_W = 2;

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = 3'd7;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = 2'd2;

  // WM8731 codec slave address with the write bit appended.
  localparam logic [7:0] WM8731_WR_ADDR = 8'h34;

  function automatic quarter_e next_quarter(input quarter_e q);
    quarter_e n;
    case (q)
      Q0:      n = Q1;
      Q1:      n = Q2;
      Q2:      n = Q3;
      default: n = Q0;
    endcase
    return n;
  endfunction

  function automatic logic scl_high(input quarter_e q);
    return (q == Q2) || (q == Q3);
  endfunction

endpackage

// File: rtl/i2c_write_engine.sv
// Three-byte I2C master write engine (address, sub-address, data).
// The bus pins and status flags are registered one cycle behind the state
// registers, so every output is glitch-free and the ACK sample point is
// taken on the edge that closes the last bus cycle of Q2.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int QPH = 1
) (
  input  logic        clk_i2c,
  input  logic        reset_n,
  input  logic [23:0] i2c_data,
  input  logic        go,
  output logic        done,
  output logic        busy,
  output logic [2:0]  ack_n,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  localparam int QW = (QPH > 1) ? $clog2(QPH) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QPH - 1);

  state_e                  state_q;
  quarter_e                qtr_q;
  logic [QW-1:0]           qcnt_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q;
  logic [23:0]             shift_q;
  logic [2:0]              ack_n_q;
  logic                    sclk_q;
  logic                    sda_low_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    sclk_d;
  logic                    sda_low_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    tick;
  logic                    slot_end;
  logic                    on_bus;

  assign tick     = (qcnt_q == QLAST);
  assign slot_end = tick && (qtr_q == Q3);
  assign on_bus   = (state_q == ST_START) || (state_q == ST_BIT) ||
                    (state_q == ST_ACK)   || (state_q == ST_STOP);

  // Decode bus levels and status flags from the current state and quarter.
  always_comb begin
    sclk_d    = 1'b1;
    sda_low_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_START: begin
        busy_d    = 1'b1;
        sda_low_d = scl_high(qtr_q);
      end
      ST_BIT: begin
        busy_d    = 1'b1;
        sclk_d    = scl_high(qtr_q);
        sda_low_d = ~shift_q[23];
      end
      ST_ACK: begin
        busy_d = 1'b1;
        sclk_d = scl_high(qtr_q);
      end
      ST_STOP: begin
        busy_d    = 1'b1;
        sclk_d    = scl_high(qtr_q);
        sda_low_d = (qtr_q != Q3);
      end
      ST_DONE: begin
        // Dropping go clears done on the same edge the FSM returns to IDLE.
        done_d = go;
      end
      default: ;
    endcase
  end

  // Transfer FSM with inline quarter, bit and byte counters plus output registers.
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      qtr_q      <= Q0;
      qcnt_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      ack_n_q    <= 3'b000;
      sclk_q     <= 1'b1;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sclk_q    <= sclk_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      done_q    <= done_d;

      if (on_bus) begin
        if (tick) begin
          qcnt_q <= '0;
          qtr_q  <= next_quarter(qtr_q);
        end else begin
          qcnt_q <= qcnt_q + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (go) begin
            shift_q    <= i2c_data;
            ack_n_q    <= 3'b000;
            qtr_q      <= Q0;
            qcnt_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (slot_end) begin
            state_q <= ST_BIT;
          end
        end
        ST_BIT: begin
          if (slot_end) begin
            shift_q <= {shift_q[22:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= ST_ACK;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_ACK: begin
          // The bus shows the last Q2 cycle while the state sits in the first Q3 cycle.
          if ((qtr_q == Q3) && (qcnt_q == '0)) begin
            ack_n_q[LAST_BYTE - byte_cnt_q] <= i2c_sdat;
          end
          if (slot_end) begin
            if (byte_cnt_q == LAST_BYTE) begin
              state_q <= ST_STOP;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= ST_BIT;
            end
          end
        end
        ST_STOP: begin
          if (slot_end) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!go) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign i2c_sclk = sclk_q;
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
  assign done     = done_q;
  assign busy     = busy_q;
  assign ack_n    = ack_n_q;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: a table of write transfers against a QPH=1
// instance with a behavioural slave, plus hand-written sequences for the
// done/go handshake, mid-transfer reset and a QPH=4 instance.
module tb_i2c_write_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] data1 = '0;
  logic        go1 = 1'b0;
  logic        done1, busy1, sclk1;
  logic [2:0]  ack1;
  wire         sda1_w;
  logic [23:0] data4 = '0;
  logic        go4 = 1'b0;
  logic        done4, busy4, sclk4;
  logic [2:0]  ack4;
  wire         sda4_w;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  // Slave pull-down for ACKs, bus pull-ups.
  logic pull = 1'b0;
  assign sda1_w = pull ? 1'b0 : 1'bz;
  pullup (sda1_w);
  pullup (sda4_w);

  i2c_write_engine #(.QPH(1)) dut1 (
    .clk_i2c(clk), .reset_n(reset_n), .i2c_data(data1), .go(go1),
    .done(done1), .busy(busy1), .ack_n(ack1), .i2c_sclk(sclk1), .i2c_sdat(sda1_w)
  );

  i2c_write_engine #(.QPH(4)) dut4 (
    .clk_i2c(clk), .reset_n(reset_n), .i2c_data(data4), .go(go4),
    .done(done4), .busy(busy4), .ack_n(ack4), .i2c_sclk(sclk4), .i2c_sdat(sda4_w)
  );

  // Behavioural slave on the QPH=1 bus: records bytes, ACKs per nack_mask.
  logic       scl1_p = 1'b1, sda1_p = 1'b1;
  int         starts1 = 0, stops1 = 0, bitn = 0, byten = 0;
  logic [7:0] rx [3];
  logic [2:0] nack_mask = 3'b000;

  always @(negedge clk) begin
    if (scl1_p && sclk1 && sda1_p && !sda1_w) begin
      starts1++; bitn = 0; byten = 0; pull = 1'b0;
    end else if (scl1_p && sclk1 && !sda1_p && sda1_w) begin
      stops1++;
    end else if (!scl1_p && sclk1) begin
      if (bitn < 8 && byten < 3) rx[byten] = {rx[byten][6:0], sda1_w};
      if (bitn < 9) bitn++;
    end else if (scl1_p && !sclk1) begin
      if (bitn == 8 && byten < 3) begin
        pull = ~nack_mask[2-byten];
      end else if (bitn == 9) begin
        pull = 1'b0; byten++; bitn = 0;
      end
    end
    scl1_p = sclk1;
    sda1_p = sda1_w;
  end

  // Monitor on the QPH=4 bus: SCL period and SDA changes while SCL high.
  logic scl4_p = 1'b1, sda4_p = 1'b1;
  int   rises4 = 0, last_rise4 = -1, pmin4 = 9999, pmax4 = 0, hi_chg4 = 0;

  always @(negedge clk) begin
    if (!scl4_p && sclk4) begin
      if (last_rise4 >= 0) begin
        if (tcyc - last_rise4 < pmin4) pmin4 = tcyc - last_rise4;
        if (tcyc - last_rise4 > pmax4) pmax4 = tcyc - last_rise4;
      end
      last_rise4 = tcyc;
      rises4++;
    end
    if (scl4_p && sclk4 && (sda4_p != sda4_w)) hi_chg4++;
    scl4_p = sclk4;
    sda4_p = sda4_w;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] data;
    logic [2:0]  nack;
    logic [2:0]  exp_ack;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    logic [7:0]  exp_b2;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    starts1 = 0; stops1 = 0; bitn = 0; byten = 0; pull = 1'b0;
    nack_mask = v.nack;
    @(posedge clk); #1 go1 = 1'b1; data1 = v.data;
    @(posedge clk); #1 data1 = $urandom;
    cyc = 0;
    @(negedge clk);
    check("ack_cleared", {29'd0, ack1}, 32'd0);
    while (!done1 && cyc < 400) begin
      @(posedge clk); cyc++; #1 data1 = $urandom;
      @(negedge clk);
    end
    check("done_cycle", cyc, 117);
    check("busy_at_done", {31'd0, busy1}, 32'd0);
    check("ack_n", {29'd0, ack1}, {29'd0, v.exp_ack});
    check("byte0", {24'd0, rx[0]}, {24'd0, v.exp_b0});
    check("byte1", {24'd0, rx[1]}, {24'd0, v.exp_b1});
    check("byte2", {24'd0, rx[2]}, {24'd0, v.exp_b2});
    check("stop_seen", stops1, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("done_held", {31'd0, done1}, 32'd1);
    check("no_restart", starts1, 1);
    check("busy_held_low", {31'd0, busy1}, 32'd0);
    check("ack_stable", {29'd0, ack1}, {29'd0, v.exp_ack});
    @(posedge clk); #1 go1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_drop", {31'd0, done1}, 32'd0);
    $display("vec %0d data=%06h ack_n=%b bytes=%02h %02h %02h done@%0d", idx, v.data, ack1,
             rx[0], rx[1], rx[2], cyc);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{24'h34_1E_00, 3'b000, 3'b000, 8'h34, 8'h1E, 8'h00};
    vecs[1] = '{24'h34_0A_5B, 3'b010, 3'b010, 8'h34, 8'h0A, 8'h5B};
    vecs[2] = '{24'hA5_FF_01, 3'b111, 3'b111, 8'hA5, 8'hFF, 8'h01};
    vecs[3] = '{24'h34_00_FF, 3'b100, 3'b100, 8'h34, 8'h00, 8'hFF};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", {31'd0, sclk1}, 32'd1);
    check("rst_sda", {31'd0, sda1_w}, 32'd1);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_ack", {29'd0, ack1}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Mid-transfer reset: bus released at once, no STOP.
    starts1 = 0; stops1 = 0; bitn = 0; byten = 0; pull = 1'b0; nack_mask = 3'b000;
    @(posedge clk); #1 go1 = 1'b1; data1 = 24'h34_1E_00;
    @(posedge clk);
    repeat (50) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_sclk", {31'd0, sclk1}, 32'd1);
    check("mid_rst_sda", {31'd0, sda1_w}, 32'd1);
    check("mid_rst_busy", {31'd0, busy1}, 32'd0);
    check("mid_rst_ack", {29'd0, ack1}, 32'd0);
    go1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_stop", stops1, 0);
    check("mid_rst_idle_sclk", {31'd0, sclk1}, 32'd1);
    $display("mid-transfer reset: stops=%0d sclk=%b sda=%b", stops1, sclk1, sda1_w);

    // Recovery after reset.
    run_vec(4, vecs[0]);

    // QPH=4 transfer with no slave present: all bytes NACKed.
    rises4 = 0; last_rise4 = -1; pmin4 = 9999; pmax4 = 0; hi_chg4 = 0;
    @(posedge clk); #1 go4 = 1'b1; data4 = 24'h34_1E_00;
    @(posedge clk); #1 data4 = $urandom;
    cyc = 0;
    @(negedge clk);
    while (!done4 && cyc < 1000) begin
      @(posedge clk); cyc++; #1 data4 = $urandom;
      @(negedge clk);
    end
    check("q4_done_cycle", cyc, 465);
    check("q4_ack_n", {29'd0, ack4}, 32'h7);
    check("q4_scl_rises", rises4, 28);
    check("q4_period_min", pmin4, 16);
    check("q4_period_max", pmax4, 16);
    check("q4_sda_hi_changes", hi_chg4, 2);
    @(posedge clk); #1 go4 = 1'b0;
    repeat (2) @(posedge clk);
    $display("qph4: done@%0d ack_n=%b rises=%0d period=%0d..%0d hi_chg=%0d", cyc, ack4,
             rises4, pmin4, pmax4, hi_chg4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
